// File: rtl/key_edge_capture.sv
// Debounced pushbutton capture with an Avalon-MM register window:
// live key state, interrupt mask, and sticky press-event flags.
module key_edge_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NKEYS           = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [NKEYS-1:0] key_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0]            r_sync1;
    logic [NKEYS-1:0]            r_sync2;
    logic [NKEYS-1:0][CNT_W-1:0] r_cnt;
    logic [NKEYS-1:0]            r_stable;
    logic [NKEYS-1:0]            r_stable_d;
    logic [NKEYS-1:0]            r_mask;
    logic [NKEYS-1:0]            r_edge;

    logic [NKEYS-1:0] w_pressed;
    logic [NKEYS-1:0] w_press_evt;
    logic [NKEYS-1:0] w_edge_clr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_pressed      = ~r_sync2;
    assign w_press_evt    = r_stable & ~r_stable_d;
    assign w_edge_clr     = (avs_write && avs_address == 2'd2) ? avs_writedata[NKEYS-1:0] : '0;
    assign w_unused_wdata = &{1'b0, avs_writedata[31:NKEYS]};

    // Synchronizers idle high so an un-pressed key looks released out of reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_export;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt      <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int k = 0; k < NKEYS; k++) begin
                if (w_pressed[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_MAX) begin
                    r_cnt[k]    <= '0;
                    r_stable[k] <= ~r_stable[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // A press event landing on the same cycle as a write-1-clear keeps the flag set.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mask <= '0;
            r_edge <= '0;
            irq    <= 1'b0;
        end else begin
            if (avs_write && avs_address == 2'd1) begin
                r_mask <= avs_writedata[NKEYS-1:0];
            end
            r_edge <= (r_edge & ~w_edge_clr) | w_press_evt;
            irq    <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            2'd0:    w_rdata[NKEYS-1:0] = r_stable;
            2'd1:    w_rdata[NKEYS-1:0] = r_mask;
            2'd2:    w_rdata[NKEYS-1:0] = r_edge;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_key_edge_capture.sv
// Directed bench for key_edge_capture with an 8-cycle debounce and 4 keys.
module tb_key_edge_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    key_edge_capture #(
        .DEBOUNCE_CYCLES(8),
        .NKEYS          (4)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_export    (key),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
        check(tag, avs_readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        key           = 4'hF;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;

        // Reset state
        tick(3);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        rst_n = 1'b1;
        tick(2);
        rd_chk(2'd0, 32'h0, "rst_data");
        rd_chk(2'd1, 32'h0, "rst_mask");
        rd_chk(2'd2, 32'h0, "rst_edge");
        rd_chk(2'd3, 32'h0, "rst_rsvd");
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk(2'd0, 32'h0, "data_ro");
        rd_chk(2'd3, 32'h0, "rsvd_ro");

        // Key 0 held for 20 cycles: stable after exactly 2+8 edges
        key[0] = 1'b0;
        tick(9);
        rd_chk(2'd0, 32'h0, "k0_data_early");
        rd_chk(2'd0, 32'h1, "k0_data");
        rd_chk(2'd2, 32'h1, "k0_edge");
        check("k0_irq_masked", {31'd0, irq}, 32'd0);
        tick(8);
        key[0] = 1'b1;
        tick(11);
        rd_chk(2'd0, 32'h0, "k0_release_data");
        rd_chk(2'd2, 32'h1, "k0_edge_sticky");
        tick(3);
        check("rdata_hold", avs_readdata, 32'h1);
        wr(2'd2, 32'h1);
        rd_chk(2'd2, 32'h0, "k0_edge_clr");

        // Key 2 glitch of 5 cycles: never accepted
        key[2] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) key[2] = 1'b1;
            if (i % 2 == 0) rd_chk(2'd0, 32'h0, "glitch_data");
            else            rd_chk(2'd2, 32'h0, "glitch_edge");
        end

        // Read and write MASK together; read sees pre-write value
        avs_address   = 2'd1;
        avs_writedata = 32'hFFFF_FFF4;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick(1);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        check("rw_pre_value", avs_readdata, 32'h0);
        rd_chk(2'd1, 32'h4, "mask_rd");

        // Key 2 press with mask set: irq one cycle after EDGE
        key[2] = 1'b0;
        tick(10);
        check("k2_irq_pre", {31'd0, irq}, 32'd0);
        tick(1);
        check("k2_irq_edge_cycle", {31'd0, irq}, 32'd0);
        tick(1);
        check("k2_irq_set", {31'd0, irq}, 32'd1);
        rd_chk(2'd2, 32'h4, "k2_edge");
        wr(2'd2, 32'h4);
        check("k2_irq_clr_lag", {31'd0, irq}, 32'd1);
        tick(1);
        check("k2_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk(2'd2, 32'h0, "k2_edge_clr");
        key[2] = 1'b1;
        tick(12);
        rd_chk(2'd2, 32'h0, "k2_release_no_evt");
        check("k2_irq_release", {31'd0, irq}, 32'd0);

        // Key 1 press event coincides with write-1-clear: set wins
        key[1] = 1'b0;
        tick(10);
        wr(2'd2, 32'h2);
        rd_chk(2'd2, 32'h2, "set_wins");
        check("k1_irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h2);
        rd_chk(2'd2, 32'h0, "k1_edge_clr");
        key[1] = 1'b1;
        tick(12);

        // Reset during key 3 debounce at count 5
        rd_chk(2'd1, 32'h4, "mask_before_rst");
        key[3] = 1'b0;
        tick(7);
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", avs_readdata, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        rd_chk(2'd2, 32'h0, "k3_edge_early");
        rd_chk(2'd2, 32'h8, "k3_edge");
        rd_chk(2'd1, 32'h0, "mask_after_rst");
        rd_chk(2'd0, 32'h8, "k3_data");
        check("k3_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
